// File: rtl/updown_wrap_tracker_if.sv
// ---------------------------------------------------------------------------
// updown_wrap_tracker_if
//
// Bundles the signals between the up/down counter side and the wrap tracker.
//
// Parameters:
//   WIDTH  width of the monitored count
//   LAP_W  width of the signed lap counter
//
// Signals:
//   M          counter mode (1 = up, 0 = down), driven by the counter side
//   cnt        counter value, driven by the counter side
//   wrap_up    one-cycle pulse on a max->0 step
//   wrap_dn    one-cycle pulse on a 0->max step
//   dir_chg    one-cycle pulse when M differs from its previous sample
//   lap        signed (two's-complement) lap count
//   ext_cnt    {lap, last sampled cnt}
//   lap_ovf    sticky lap saturation flag
//   step_err   sticky non-unit jump flag (0 unless jump checking is built in)
//   state_dbg  tracker state (0 = SYNC, 1 = TRACK)
//
// Modports:
//   master  counter / observer side: drives M and cnt, reads tracker outputs
//   slave   tracker side: reads M and cnt, drives everything else
//
// Handshake: there is none. cnt and M are sampled on every rising clock
// edge; there is no valid/ready qualification of either direction.
// ---------------------------------------------------------------------------
interface updown_wrap_tracker_if #(
  parameter int WIDTH = 4,
  parameter int LAP_W = 4
);
  logic                   M;
  logic [WIDTH-1:0]       cnt;
  logic                   wrap_up;
  logic                   wrap_dn;
  logic                   dir_chg;
  logic [LAP_W-1:0]       lap;
  logic [LAP_W+WIDTH-1:0] ext_cnt;
  logic                   lap_ovf;
  logic                   step_err;
  logic                   state_dbg;

  modport master (
    output M, cnt,
    input  wrap_up, wrap_dn, dir_chg, lap, ext_cnt, lap_ovf, step_err, state_dbg
  );

  modport slave (
    input  M, cnt,
    output wrap_up, wrap_dn, dir_chg, lap, ext_cnt, lap_ovf, step_err, state_dbg
  );
endinterface

// File: rtl/updown_wrap_tracker.sv
// ---------------------------------------------------------------------------
// updown_wrap_tracker
//
// Downstream monitor for a WIDTH-bit up/down counter. Every edge it samples
// the count and the mode bit, classifies the step (up, down, hold, jump),
// pulses on wrap-around and on direction change, and keeps a saturating
// signed lap count. {lap, cnt_q} forms an extended-width position.
//
// Parameters:
//   WIDTH  width of the monitored count (>= 2)
//   LAP_W  width of the signed lap counter
//
// Ports:
//   clk  rising-edge clock, shared with the counter
//   rst  synchronous active-low reset
//   bus  updown_wrap_tracker_if.slave: M/cnt in; wrap_up, wrap_dn, dir_chg,
//        lap, ext_cnt, lap_ovf, step_err, state_dbg out
//
// Build option:
//   UDWT_STEP_CHECK_EN  when defined, a non-unit jump sets sticky step_err.
//                       When undefined, step_err is tied 0 and a jump is a
//                       silent resync.
//
// All outputs come from flops; ext_cnt is a concatenation of two registers
// that update on the same edge, so it is never torn.
// ---------------------------------------------------------------------------
module updown_wrap_tracker #(
  parameter int WIDTH = 4,
  parameter int LAP_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  updown_wrap_tracker_if.slave bus
);

  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [LAP_W-1:0] LAP_ONE = LAP_W'(1);
  // Most positive and most negative two's-complement lap values.
  localparam logic [LAP_W-1:0] LAP_HI  = {1'b0, {(LAP_W-1){1'b1}}};
  localparam logic [LAP_W-1:0] LAP_LO  = {1'b1, {(LAP_W-1){1'b0}}};

  state_t           state;
  logic [WIDTH-1:0] cnt_q;
  logic             m_q;
  logic             wrap_up_q;
  logic             wrap_dn_q;
  logic             dir_chg_q;
  logic [LAP_W-1:0] lap_q;
  logic             lap_ovf_q;

  // Neighbours of the last sample, wrapping mod 2^WIDTH.
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] cnt_dec;
  logic             is_up;
  logic             is_dn;

  assign cnt_inc = cnt_q + CNT_ONE;
  assign cnt_dec = cnt_q - CNT_ONE;
  assign is_up   = (bus.cnt == cnt_inc);
  assign is_dn   = (bus.cnt == cnt_dec);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= SYNC;
      cnt_q     <= '0;
      m_q       <= 1'b0;
      wrap_up_q <= 1'b0;
      wrap_dn_q <= 1'b0;
      dir_chg_q <= 1'b0;
      lap_q     <= '0;
      lap_ovf_q <= 1'b0;
    end else begin
      // Pulses default low; samples are refreshed on every non-reset edge,
      // which also makes a jump a plain resync.
      wrap_up_q <= 1'b0;
      wrap_dn_q <= 1'b0;
      dir_chg_q <= 1'b0;
      cnt_q     <= bus.cnt;
      m_q       <= bus.M;
      case (state)
        SYNC: begin
          // First edge after reset only captures; no history to compare.
          state <= TRACK;
        end
        TRACK: begin
          dir_chg_q <= (bus.M != m_q);
          if (is_up && (cnt_q == CNT_MAX)) begin
            wrap_up_q <= 1'b1;
            if (lap_q == LAP_HI) lap_ovf_q <= 1'b1;
            else                 lap_q     <= lap_q + LAP_ONE;
          end else if (is_dn && (cnt_q == '0)) begin
            wrap_dn_q <= 1'b1;
            if (lap_q == LAP_LO) lap_ovf_q <= 1'b1;
            else                 lap_q     <= lap_q - LAP_ONE;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

`ifdef UDWT_STEP_CHECK_EN
  logic step_err_q;
  logic is_jump;

  // Anything other than up, down or hold is a jump.
  assign is_jump = !is_up && !is_dn && (bus.cnt != cnt_q);

  always_ff @(posedge clk) begin
    if (!rst)                           step_err_q <= 1'b0;
    else if (state == TRACK && is_jump) step_err_q <= 1'b1;
  end

  assign bus.step_err = step_err_q;
`else
  assign bus.step_err = 1'b0;
`endif

  assign bus.wrap_up   = wrap_up_q;
  assign bus.wrap_dn   = wrap_dn_q;
  assign bus.dir_chg   = dir_chg_q;
  assign bus.lap       = lap_q;
  assign bus.ext_cnt   = {lap_q, cnt_q};
  assign bus.lap_ovf   = lap_ovf_q;
  assign bus.state_dbg = state;

endmodule

// File: doc/updown_wrap_tracker.md
# updown_wrap_tracker

Downstream monitor for the 4-bit up/down counter. It samples the counter's `cnt` output and its mode input `M` every clock, and classifies each step as up, down, hold or jump. It raises one-cycle pulses on wrap-around and on direction change, and keeps a signed lap count. Together with the sampled count, the lap count forms an extended-width position `ext_cnt`, which is consumed by the display/logging stage.

## Interface
Parameters:
- `WIDTH`, 4: width of the monitored count. Must be ≥ 2.
- `LAP_W`, 4: width of the signed (two's-complement) lap counter.

Ports:
- `clk`  in  1  rising-edge clock, shared with the counter.
- `rst`  in  1  reset, synchronous, active-low.
- `M`  in  1  counter mode: 1 = up, 0 = down.
- `cnt`  in  WIDTH  counter output, sampled every edge.
- `wrap_up`  out  1  one-cycle pulse on a max→0 step.
- `wrap_dn`  out  1  one-cycle pulse on a 0→max step.
- `dir_chg`  out  1  one-cycle pulse when `M` differs from its previous sample.
- `lap`  out  LAP_W  signed lap count.
- `ext_cnt`  out  LAP_W+WIDTH  equal to `{lap, cnt_q}`, where `cnt_q` is the last sampled `cnt`.
- `lap_ovf`  out  1  sticky; lap saturated.
- `step_err`  out  1  sticky; non-unit jump detected. Tied 0 unless the macro is defined.

## Operation
- Internal registers: `cnt_q`, `M_q` and a state register. States are SYNC and TRACK.
- Reset (`rst`=0 at an edge):
  - All outputs and registers go to 0.
  - State goes to SYNC.
- SYNC, one edge:
  - Capture `cnt`→`cnt_q` and `M`→`M_q`.
  - No pulses; `lap` unchanged.
  - Go to TRACK.
- TRACK, at each edge compare `cnt` against `cnt_q`. Arithmetic is mod 2^WIDTH and MAX = 2^WIDTH−1.
  - `cnt == cnt_q+1`: up step. If `cnt_q==MAX`, pulse `wrap_up` and increment `lap`.
  - `cnt == cnt_q−1`: down step. If `cnt_q==0`, pulse `wrap_dn` and decrement `lap`.
  - `cnt == cnt_q`: hold. No event.
  - Any other value: jump.
    - `lap` unchanged.
    - `step_err` set (macro builds only).
    - Tracking resyncs to the new value; state stays TRACK.
  - `cnt_q` is updated to `cnt` on every TRACK edge.
  - `M != M_q` pulses `dir_chg`, and `M_q` is then updated.
- Lap saturation:
  - Incrementing at +2^(LAP_W−1)−1, or decrementing at −2^(LAP_W−1), leaves `lap` unchanged and sets `lap_ovf`.
  - The wrap pulse still fires.
- `lap_ovf` and `step_err` clear only on reset.
- Simultaneous events: `dir_chg` and a wrap pulse may assert in the same cycle. Both are reported.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- Latency: `cnt` presenting a wrapped value before edge k produces the pulse during cycle k→k+1.
- At that same edge, `lap` and `cnt_q` update together, so `ext_cnt` is never torn.
- Pulses are exactly one cycle wide. Back-to-back wraps (e.g. WIDTH=2 counting fast) give back-to-back pulses.
- Reset mid-operation:
  - Outputs are 0 in the cycle after the reset edge.
  - The first post-reset edge is SYNC. A 15→0 transition spanning reset is not counted.
- `rst` deasserted: the first TRACK comparison happens at the second edge after deassertion.

## Configuration
- Macro `UDWT_STEP_CHECK_EN`.
- Defined:
  - Jump detection drives sticky `step_err`.
  - Comparator and flag flop are present.
- Undefined:
  - `step_err` is constant 0.
  - A jump is treated as a silent resync: `lap` unchanged, `cnt_q` takes the new value.
  - All other behaviour is identical.

## Test plan
- Reset, then `M`=1 with the counter running from 0 for 20 cycles:
  - Exactly one `wrap_up`, in the cycle after `cnt` shows 0 following 15.
  - `lap`=1; `ext_cnt` steps 0x0F→0x10.
  - `wrap_dn`=0, `dir_chg`=0.
- From `lap`=1, `cnt`=4, switch `M`=0:
  - `dir_chg` pulses once.
  - After `cnt` goes 0→15, `wrap_dn` pulses and `lap`=0, giving `ext_cnt`=0x0F.
- LAP_W=2, up-count through 3 wraps:
  - `lap` goes 1 and stays 1 (saturated).
  - `lap_ovf`=1 from the second wrap onward.
  - 3 `wrap_up` pulses.
- Drive `cnt` 3→9 with the macro defined:
  - `step_err`=1 and stays set.
  - `lap` unchanged; the next 9→10 step is a normal up step.
  - Without the macro, `step_err` stays 0.
- Assert `rst`=0 for one edge while `lap`=2:
  - All outputs are 0 the next cycle.
  - Resume with `cnt` at 0 after a pre-reset value of 15: no `wrap_up`, `lap` stays 0.
- `M` toggles on the same edge a 15→0 step is sampled: `dir_chg` and `wrap_up` are both high in the same cycle, and `lap` increments.
